// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the loader, the data-memory BRAM and dmem_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_wdata;
    logic [31:0]       core_rdata;
    logic              core_rvalid;
    logic              stall_m;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_grant;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  ld_req, ld_addr, ld_wdata, mem_dout,
        output core_rdata, core_rvalid, stall_m, ld_grant,
        output mem_en, mem_we, mem_addr, mem_din
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output ld_req, ld_addr, ld_wdata, mem_dout,
        input  core_rdata, core_rvalid, stall_m, ld_grant,
        input  mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data BRAM between MEM-stage loads/stores and the UART loader,
// stalls the pipeline across multi-cycle reads and bounds loader starvation.
module dmem_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int RD_LAT       = 1,
    parameter int MAX_CORE_RUN = 8
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RD_WAIT = 1'b1;
    localparam int RUN_W = $clog2(MAX_CORE_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CORE_RUN);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [1:0] LAT_MAX = 2'(RD_LAT);

    logic [0:0]        state_r, state_nxt_s;
    logic [1:0]        lat_cnt_r, lat_nxt_s;
    logic [RUN_W-1:0]  run_cnt_r, run_nxt_s;
    logic [31:0]       rdata_r;

    logic              ld_win_s;
    logic              en_s, we_s, stall_s, grant_s, rvalid_s;
    logic [ADDR_W-1:0] addr_s;
    logic [31:0]       din_s;

    assign ld_win_s = bus.ld_req && (!bus.core_req || (run_cnt_r == RUN_MAX));

    // Arbitration, BRAM drive and next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        lat_nxt_s   = lat_cnt_r;
        run_nxt_s   = run_cnt_r;
        en_s        = 1'b0;
        we_s        = 1'b0;
        addr_s      = '0;
        din_s       = 32'h0000_0000;
        stall_s     = 1'b0;
        grant_s     = 1'b0;
        rvalid_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ld_win_s) begin
                    en_s      = 1'b1;
                    we_s      = 1'b1;
                    addr_s    = bus.ld_addr;
                    din_s     = bus.ld_wdata;
                    grant_s   = 1'b1;
                    stall_s   = bus.core_req;
                    run_nxt_s = '0;
                end else if (bus.core_req) begin
                    en_s   = 1'b1;
                    we_s   = bus.core_we;
                    addr_s = bus.core_addr;
                    din_s  = bus.core_wdata;
                    // The run count only matters while the loader is actually waiting.
                    if (bus.ld_req) begin
                        run_nxt_s = (run_cnt_r == RUN_MAX) ? RUN_MAX : run_cnt_r + RUN_ONE;
                    end else begin
                        run_nxt_s = '0;
                    end
                    if (!bus.core_we) begin
                        stall_s     = 1'b1;
                        state_nxt_s = ST_RD_WAIT;
                        lat_nxt_s   = 2'd1;
                    end else begin
                        stall_s     = 1'b0;
                    end
                end else begin
                    run_nxt_s = '0;
                end
            end
            ST_RD_WAIT: begin
                addr_s = bus.core_addr;
                if (lat_cnt_r < LAT_MAX) begin
                    stall_s   = 1'b1;
                    lat_nxt_s = lat_cnt_r + 2'd1;
                end else begin
                    rvalid_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                    lat_nxt_s   = 2'd0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                lat_nxt_s   = 2'd0;
                run_nxt_s   = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is held, even with requests pending.
    assign bus.mem_en      = rst_n & en_s;
    assign bus.mem_we      = rst_n & we_s;
    assign bus.mem_addr    = rst_n ? addr_s : '0;
    assign bus.mem_din     = rst_n ? din_s : 32'h0000_0000;
    assign bus.ld_grant    = rst_n & grant_s;
    assign bus.stall_m     = rst_n & stall_s & bus.core_req;
    assign bus.core_rvalid = rst_n & rvalid_s;
    assign bus.core_rdata  = !rst_n ? 32'h0000_0000 : (rvalid_s ? bus.mem_dout : rdata_r);

    // FSM, latency counter and starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            lat_cnt_r <= 2'd0;
            run_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            lat_cnt_r <= lat_nxt_s;
            run_cnt_r <= run_nxt_s;
        end
    end

    // Load data register, held until the next load completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'h0000_0000;
        end else if (rvalid_s) begin
            rdata_r <= bus.mem_dout;
        end else begin
            rdata_r <= rdata_r;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;
    localparam int AW     = 15;
    localparam int RD_LAT = 2;
    localparam int MAXRUN = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW)) bus();

    dmem_arbiter #(.ADDR_W(AW), .RD_LAT(RD_LAT), .MAX_CORE_RUN(MAXRUN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // BRAM environment model with RD_LAT-stage read pipeline.
    logic [31:0] bram [0:(1<<AW)-1];
    logic [31:0] rd_pipe [0:RD_LAT-1];
    assign bus.mem_dout = rd_pipe[RD_LAT-1];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) bram[bus.mem_addr] <= bus.mem_din;
        if (bus.mem_en && !bus.mem_we) rd_pipe[0] <= bram[bus.mem_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [AW-1:0] ca,
                         input logic [31:0] cd, input logic lreq, input logic [AW-1:0] la,
                         input logic [31:0] lwd);
        bus.core_req   = creq;
        bus.core_we    = cwe;
        bus.core_addr  = ca;
        bus.core_wdata = cd;
        bus.ld_req     = lreq;
        bus.ld_addr    = la;
        bus.ld_wdata   = lwd;
    endtask

    typedef struct packed {
        logic          creq;
        logic          cwe;
        logic [AW-1:0] caddr;
        logic [31:0]   cwd;
        logic          lreq;
        logic [AW-1:0] laddr;
        logic [31:0]   lwd;
        logic          e_stall;
        logic          e_grant;
        logic          e_rvalid;
        logic          e_en;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_rdata;
    } vec_t;

    vec_t tbl [16];

    // Reference model state for the random phase.
    logic [31:0] shadow [int];
    function automatic logic [31:0] shadow_rd(input int a);
        return shadow.exists(a) ? shadow[a] : 32'h0;
    endfunction

    initial begin
        int cg, lg, lg_at, ci, rv_cnt;
        logic st_at_lg, lp;
        int rd_left, streak;
        logic [31:0] last_rd;
        logic prev_stall, ld_pend;
        logic creq, cwe, lreq;
        logic [AW-1:0] ca, la;
        logic [31:0] cd, lwd;
        logic e_stall, e_grant, e_rv, e_en, e_we;
        logic [31:0] e_rd;

        for (int i = 0; i < (1<<AW); i++) bram[i] = 32'h0;
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 32'h0;

        tbl[0]  = '{1'b0,1'b0,15'h00,32'h0,       1'b1,15'h10,32'hDEADBEEF, 1'b0,1'b1,1'b0,1'b1,1'b1,15'h10,32'h0};
        tbl[1]  = '{1'b1,1'b0,15'h10,32'h0,       1'b0,15'h00,32'h0,        1'b1,1'b0,1'b0,1'b1,1'b0,15'h10,32'h0};
        tbl[2]  = '{1'b1,1'b0,15'h10,32'h0,       1'b0,15'h00,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,15'h10,32'h0};
        tbl[3]  = '{1'b1,1'b0,15'h10,32'h0,       1'b0,15'h00,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,15'h10,32'hDEADBEEF};
        tbl[4]  = '{1'b1,1'b1,15'h20,32'h12345678,1'b0,15'h00,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b1,15'h20,32'hDEADBEEF};
        tbl[5]  = '{1'b1,1'b0,15'h20,32'h0,       1'b0,15'h00,32'h0,        1'b1,1'b0,1'b0,1'b1,1'b0,15'h20,32'hDEADBEEF};
        tbl[6]  = '{1'b1,1'b0,15'h20,32'h0,       1'b0,15'h00,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,15'h20,32'hDEADBEEF};
        tbl[7]  = '{1'b1,1'b0,15'h20,32'h0,       1'b0,15'h00,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,15'h20,32'h12345678};
        for (int i = 0; i < 4; i++)
            tbl[8+i] = '{1'b0,1'b0,15'h00,32'h0, 1'b1,15'(i),32'hA0 + 32'(i),
                         1'b0,1'b1,1'b0,1'b1,1'b1,15'(i),32'h12345678};
        tbl[12] = '{1'b1,1'b0,15'h02,32'h0,       1'b0,15'h00,32'h0,        1'b1,1'b0,1'b0,1'b1,1'b0,15'h02,32'h12345678};
        tbl[13] = '{1'b1,1'b0,15'h02,32'h0,       1'b0,15'h00,32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,15'h02,32'h12345678};
        tbl[14] = '{1'b1,1'b0,15'h02,32'h0,       1'b0,15'h00,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,15'h02,32'h000000A2};
        tbl[15] = '{1'b0,1'b0,15'h00,32'h0,       1'b0,15'h00,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,15'h00,32'h000000A2};

        // Reset with requests pending: every output must stay low.
        drive(1'b1, 1'b0, 15'h10, 32'h0, 1'b1, 15'h11, 32'h1);
        #2;
        chk("rst_stall", 32'(bus.stall_m), 32'h0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
        chk("rst_ld_grant", 32'(bus.ld_grant), 32'h0);
        chk("rst_rvalid", 32'(bus.core_rvalid), 32'h0);
        chk("rst_rdata", bus.core_rdata, 32'h0);
        drive(1'b0, 1'b0, 15'h0, 32'h0, 1'b0, 15'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            drive(tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd, tbl[i].lreq, tbl[i].laddr, tbl[i].lwd);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(bus.stall_m), 32'(tbl[i].e_stall));
            chk($sformatf("v%0d_grant", i), 32'(bus.ld_grant), 32'(tbl[i].e_grant));
            chk($sformatf("v%0d_rvalid", i), 32'(bus.core_rvalid), 32'(tbl[i].e_rvalid));
            chk($sformatf("v%0d_en", i), 32'(bus.mem_en), 32'(tbl[i].e_en));
            chk($sformatf("v%0d_we", i), 32'(bus.mem_we), 32'(tbl[i].e_we));
            chk($sformatf("v%0d_rdata", i), bus.core_rdata, tbl[i].e_rdata);
            if (tbl[i].e_en) chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr), 32'(tbl[i].e_addr));
        end

        // Starvation guard: 12 cycles of core stores with the loader waiting.
        cg = 0; lg = 0; lg_at = -1; ci = 0; st_at_lg = 1'b0; lp = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            drive(1'b1, 1'b1, 15'(8'h30 + ci), 32'(ci), lp, 15'h40, 32'h55);
            @(negedge clk);
            if (bus.ld_grant) begin
                lg++; lg_at = k; st_at_lg = bus.stall_m; lp = 1'b0;
            end else if (bus.mem_en && bus.mem_we) begin
                cg++; ci++;
            end
        end
        chk("guard_core_run", 32'(lg_at), 32'd8);
        chk("guard_ld_grants", 32'(lg), 32'd1);
        chk("guard_stall", 32'(st_at_lg), 32'd1);
        chk("guard_core_grants", 32'(cg), 32'd11);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 15'h0, 32'h0, 1'b0, 15'h0, 32'h0);

        // Core load collides with loader: core first, loader right after.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            drive(k < 3, 1'b0, 15'h10, 32'h0, 1'b1, 15'h50, 32'h77);
            @(negedge clk);
            chk($sformatf("coll%0d_grant", k), 32'(bus.ld_grant), (k == 3) ? 32'd1 : 32'd0);
            chk($sformatf("coll%0d_stall", k), 32'(bus.stall_m), (k < 2) ? 32'd1 : 32'd0);
            chk($sformatf("coll%0d_rvalid", k), 32'(bus.core_rvalid), (k == 2) ? 32'd1 : 32'd0);
        end
        chk("coll_rdata", bus.core_rdata, 32'hDEADBEEF);

        // Reset during RD_WAIT.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 15'h50, 32'h0, 1'b0, 15'h0, 32'h0);
        @(negedge clk);
        chk("mid_rst_pre_stall", 32'(bus.stall_m), 32'd1);
        @(posedge clk); #1;
        bus.ld_req = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(bus.stall_m), 32'd0);
        chk("mid_rst_en", 32'(bus.mem_en), 32'd0);
        chk("mid_rst_grant", 32'(bus.ld_grant), 32'd0);
        chk("mid_rst_rdata", bus.core_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 15'h0, 32'h0, 1'b0, 15'h0, 32'h0);
        rst_n = 1'b1;
        rv_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.core_rvalid) rv_cnt++;
        end
        chk("post_rst_rvalid", 32'(rv_cnt), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            drive(1'b1, 1'b0, 15'h50, 32'h0, 1'b0, 15'h0, 32'h0);
            @(negedge clk);
        end
        chk("post_rst_load_rvalid", 32'(bus.core_rvalid), 32'd1);
        chk("post_rst_load_rdata", bus.core_rdata, 32'h77);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 15'h0, 32'h0, 1'b0, 15'h0, 32'h0);
        @(negedge clk);
        chk("rdata_hold", bus.core_rdata, 32'h77);

        // Randomized traffic against the transaction-level model.
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd_left = 0; streak = 0; last_rd = 32'h0; prev_stall = 1'b0; ld_pend = 1'b0;
        creq = 1'b0; cwe = 1'b0; ca = '0; cd = 32'h0; lreq = 1'b0; la = '0; lwd = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!prev_stall) begin
                creq = ($urandom % 4) != 0;
                cwe  = $urandom % 2;
                ca   = 15'(12'h100 + $urandom_range(0, 15));
                cd   = $urandom;
            end
            if (!ld_pend) begin
                lreq = ($urandom % 3) == 0;
                la   = 15'(12'h100 + $urandom_range(0, 15));
                lwd  = $urandom;
            end
            drive(creq, cwe, ca, cd, lreq, la, lwd);
            @(negedge clk);
            e_stall = 1'b0; e_grant = 1'b0; e_rv = 1'b0; e_en = 1'b0; e_we = 1'b0; e_rd = last_rd;
            if (rd_left > 0) begin
                if (rd_left == 1) begin
                    e_rv = 1'b1; e_rd = shadow_rd(int'(ca)); last_rd = e_rd;
                end else begin
                    e_stall = 1'b1;
                end
                rd_left--;
            end else if (lreq && (!creq || streak >= MAXRUN)) begin
                e_grant = 1'b1; e_en = 1'b1; e_we = 1'b1; e_stall = creq;
                shadow[int'(la)] = lwd; streak = 0;
            end else if (creq) begin
                e_en = 1'b1; e_we = cwe;
                streak = lreq ? ((streak >= MAXRUN) ? MAXRUN : streak + 1) : 0;
                if (cwe) shadow[int'(ca)] = cd;
                else begin e_stall = 1'b1; rd_left = RD_LAT; end
            end else begin
                streak = 0;
            end
            chk($sformatf("r%0d_stall", c), 32'(bus.stall_m), 32'(e_stall));
            chk($sformatf("r%0d_grant", c), 32'(bus.ld_grant), 32'(e_grant));
            chk($sformatf("r%0d_rvalid", c), 32'(bus.core_rvalid), 32'(e_rv));
            chk($sformatf("r%0d_en", c), 32'(bus.mem_en), 32'(e_en));
            chk($sformatf("r%0d_we", c), 32'(bus.mem_we), 32'(e_we));
            chk($sformatf("r%0d_rdata", c), bus.core_rdata, e_rd);
            prev_stall = e_stall;
            ld_pend = lreq && !e_grant;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
